// File: rtl/i2c_target_regs.sv
// I2C target with a 7-bit address match and an 8-bit register pointer driving an external register file.
// SDA is open-drain (released or pulled low only); SCL is observed only, never stretched.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 3,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic       sel_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  logic                  scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic                  sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic [FILTER_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                  scl_p_q, scl_p_d, sda_p_q, sda_p_d;

  state_e                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic                  mack_q, mack_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                  sda_t_q, sda_t_d;
  logic [7:0]            reg_addr_q, reg_addr_d;
  logic [7:0]            reg_wdata_q, reg_wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  rd_lat_q, rd_lat_d;
  logic                  busy_q, busy_d;
  logic                  sel_q, sel_d;

  logic                  scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  logic                  drive_val;
  logic [7:0]            rx_byte;

  // A new level is accepted only once FILTER_LEN consecutive synced samples agree.
  always_comb begin
    scl_s1_d   = scl_i;
    scl_s2_d   = scl_s1_q;
    sda_s1_d   = sda_i;
    sda_s2_d   = sda_s1_q;
    scl_hist_d = {scl_hist_q[FILTER_LEN-2:0], scl_s2_q};
    sda_hist_d = {sda_hist_q[FILTER_LEN-2:0], sda_s2_q};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    if (&scl_hist_q)       scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    if (&sda_hist_q)       sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
  end

  assign scl_rise   = scl_f_q & ~scl_p_q;
  assign scl_fall   = ~scl_f_q & scl_p_q;
  assign sda_rise   = sda_f_q & ~sda_p_q;
  assign sda_fall   = ~sda_f_q & sda_p_q;
  assign start_cond = sda_fall & scl_f_q & scl_p_q;
  assign stop_cond  = sda_rise & scl_f_q & scl_p_q;
  assign rx_byte    = {shift_q[6:0], sda_f_q};

  always_comb begin
    drive_val = 1'b1;
    case (state_q)
      ADDR_ACK, PTR_ACK, WDATA_ACK: drive_val = 1'b0;
      RDATA:                        drive_val = shift_q[7];
      default:                      drive_val = 1'b1;
    endcase
  end

  // Bit-level FSM: rises sample/count bits, falls advance byte phases and arm the SDA hold timer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    hold_cnt_d  = hold_cnt_q;
    sda_t_d     = sda_t_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rd_lat_d    = re_q;
    busy_d      = busy_q;
    sel_d       = sel_q;

    if (rd_lat_q) shift_d = reg_rdata_i;

    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
      if (hold_cnt_q == HW'(1)) sda_t_d = drive_val;
    end

    if (start_cond) begin
      state_d    = ADDR;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b1;
      sel_d      = 1'b0;
      sda_t_d    = 1'b1;
      hold_cnt_d = '0;
    end else if (stop_cond) begin
      state_d    = IDLE;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b0;
      sel_d      = 1'b0;
      sda_t_d    = 1'b1;
      hold_cnt_d = '0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                sel_d   = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == PTR) begin
              reg_addr_d = rx_byte;
              state_d    = PTR_ACK;
            end else begin
              reg_wdata_d = rx_byte;
              we_d        = 1'b1;
              state_d     = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA: bit_cnt_d = bit_cnt_q + 4'd1;
        RDATA_ACK: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          mack_d    = sda_f_q;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_cnt_d = HOLD_INIT;
      case (state_q)
        ADDR_ACK: if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            re_d    = 1'b1;
            state_d = RDATA;
          end else begin
            state_d = PTR;
          end
        end
        PTR_ACK: if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          state_d   = WDATA;
        end
        WDATA_ACK: if (bit_cnt_q == 4'd9) begin
          bit_cnt_d  = 4'd0;
          reg_addr_d = reg_addr_q + 8'd1;
          state_d    = WDATA;
        end
        RDATA: begin
          if (bit_cnt_q == 4'd8) state_d = RDATA_ACK;
          else                   shift_d = {shift_q[6:0], 1'b0};
        end
        RDATA_ACK: if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          if (!mack_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
            re_d       = 1'b1;
            state_d    = RDATA;
          end else begin
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      scl_hist_q  <= '1;
      sda_hist_q  <= '1;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      hold_cnt_q  <= '0;
      sda_t_q     <= 1'b1;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rd_lat_q    <= 1'b0;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      scl_f_q     <= scl_f_d;
      sda_f_q     <= sda_f_d;
      scl_p_q     <= scl_p_d;
      sda_p_q     <= sda_p_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      hold_cnt_q  <= hold_cnt_d;
      sda_t_q     <= sda_t_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rd_lat_q    <= rd_lat_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_t       = sda_t_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;
  assign sel_o       = sel_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged bus master, a wired-AND SDA line and a register file
// that returns addr^0xFF; single-byte writes come from a vector table, corner cases are scripted.
module tb_i2c_target_regs;

  localparam int Q = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o, sda_t;
  logic [7:0] reg_addr, reg_wdata, rdata;
  logic       reg_we, reg_re, busy, sel;
  logic       sda_line;

  int checks = 0;
  int errors = 0;

  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         re_count = 0;
  logic       sda_t_prev = 1'b1;

  assign sda_line = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_target_regs dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_t      (sda_t),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_re_o   (reg_re),
    .reg_rdata_i(rdata),
    .busy_o     (busy),
    .sel_o      (sel)
  );

  always #5 clk = ~clk;

  initial rdata = 8'h00;

  // Register file model and strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) begin
      re_count++;
      rdata = reg_addr ^ 8'hFF;
    end
  end

  // The target may only start pulling SDA low while SCL is low.
  always @(negedge clk) begin
    if (sda_t_prev && !sda_t) begin
      checks++;
      if (scl_m) begin
        errors++;
        $display("[TB] FAIL sda_pull_scl_high: sda_t fell with scl=%0b, required scl=0", scl_m);
      end
    end
    sda_t_prev = sda_t;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_nack);
    logic [7:0] v;
    logic       bit_v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(bit_v);
      v = {v[6:0], bit_v};
    end
    send_bit(master_nack);
    b = v;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_count = 0;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  // One single-byte write transaction; a NACKed address ends with STOP straight away.
  task automatic applyStimulus(input wr_vec_t v);
    logic ack;
    clear_logs();
    i2c_start();
    checkOutput("busy_after_start", busy, 1);
    write_byte(v.dev, ack);
    checkOutput("addr_ack", ack, !v.exp_ack);
    checkOutput("sel_after_addr", sel, v.exp_ack);
    checkOutput("busy_during", busy, 1);
    if (v.exp_ack) begin
      write_byte(v.ptr, ack);
      checkOutput("ptr_ack", ack, 0);
      write_byte(v.data, ack);
      checkOutput("data_ack", ack, 0);
      checkOutput("ptr_incr", reg_addr, v.ptr + 8'd1);
    end
    i2c_stop();
    wait_q();
    checkOutput("busy_after_stop", busy, 0);
    checkOutput("sel_after_stop", sel, 0);
    checkOutput("we_count", we_addr_q.size(), v.exp_ack ? 1 : 0);
    checkOutput("re_count", re_count, 0);
    if (we_addr_q.size() > 0) begin
      checkOutput("we_addr", we_addr_q[0], v.ptr);
      checkOutput("we_data", we_data_q[0], v.data);
    end
  endtask

  wr_vec_t vecs[5];

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic       bit_v;

    vecs[0] = '{dev: 8'hA0, ptr: 8'h10, data: 8'h55, exp_ack: 1'b1};
    vecs[1] = '{dev: 8'hA0, ptr: 8'h80, data: 8'h3C, exp_ack: 1'b1};
    vecs[2] = '{dev: 8'h42, ptr: 8'h10, data: 8'h77, exp_ack: 1'b0};
    vecs[3] = '{dev: 8'hA2, ptr: 8'h33, data: 8'h44, exp_ack: 1'b0};
    vecs[4] = '{dev: 8'hA0, ptr: 8'h7E, data: 8'hC3, exp_ack: 1'b1};

    $display("[TB] reset");
    reset_dut();
    checkOutput("rst_sda_t", sda_t, 1);
    checkOutput("rst_sda_o", sda_o, 0);
    checkOutput("rst_we", reg_we, 0);
    checkOutput("rst_re", reg_re, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_addr", reg_addr, 0);
    checkOutput("rst_wdata", reg_wdata, 0);
    wait_q(); wait_q();

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] two-byte write");
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); checkOutput("w2_addr_ack", ack, 0);
    write_byte(8'h10, ack); checkOutput("w2_ptr_ack", ack, 0);
    write_byte(8'h55, ack); checkOutput("w2_d0_ack", ack, 0);
    write_byte(8'hAA, ack); checkOutput("w2_d1_ack", ack, 0);
    i2c_stop();
    checkOutput("w2_we_count", we_addr_q.size(), 2);
    if (we_addr_q.size() == 2) begin
      checkOutput("w2_a0", we_addr_q[0], 8'h10);
      checkOutput("w2_d0", we_data_q[0], 8'h55);
      checkOutput("w2_a1", we_addr_q[1], 8'h11);
      checkOutput("w2_d1", we_data_q[1], 8'hAA);
    end

    $display("[TB] combined read");
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack); checkOutput("rd_addr_ack", ack, 0);
    write_byte(8'h20, ack); checkOutput("rd_ptr_ack", ack, 0);
    i2c_start();
    write_byte(8'hA1, ack); checkOutput("rd_addr2_ack", ack, 0);
    checkOutput("rd_sel", sel, 1);
    read_byte(rb, 1'b0);    checkOutput("rd_byte0", rb, 8'hDF);
    read_byte(rb, 1'b1);    checkOutput("rd_byte1", rb, 8'hDE);
    checkOutput("rd_nack_release", sda_t, 1);
    i2c_stop();
    checkOutput("rd_re_count", re_count, 2);
    checkOutput("rd_we_count", we_addr_q.size(), 0);
    checkOutput("rd_final_ptr", reg_addr, 8'h21);

    $display("[TB] pointer wrap");
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); checkOutput("wrap_ack", ack, 0);
    i2c_stop();
    checkOutput("wrap_we_count", we_addr_q.size(), 2);
    if (we_addr_q.size() == 2) begin
      checkOutput("wrap_a0", we_addr_q[0], 8'hFF);
      checkOutput("wrap_d0", we_data_q[0], 8'h11);
      checkOutput("wrap_a1", we_addr_q[1], 8'h00);
      checkOutput("wrap_d1", we_data_q[1], 8'h22);
    end

    $display("[TB] glitch");
    wait_q();
    @(posedge clk); #1 sda_m = 1'b0;
    @(posedge clk); #1 sda_m = 1'b1;
    wait_q();
    checkOutput("glitch_busy", busy, 0);

    $display("[TB] mid-byte stop");
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    wait_q();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_we_count", we_addr_q.size(), 0);
    checkOutput("abort_ptr", reg_addr, 8'h30);

    $display("[TB] reset during read");
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    get_bit(bit_v); checkOutput("rrst_bit7", bit_v, 1);
    get_bit(bit_v); checkOutput("rrst_bit6", bit_v, 1);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    checkOutput("rrst_driving", sda_t, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rrst_release", sda_t, 1);
    rst = 1'b0;
    wait_q();
    scl_m = 1'b0; wait_q();
    i2c_stop();
    wait_q();
    checkOutput("rrst_busy", busy, 0);
    checkOutput("rrst_sel", sel, 0);
    checkOutput("rrst_ptr", reg_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
